// File: rtl/seq_alu_md.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide with a HI result register.
module seq_alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dbz_q, dbz_d;
    logic             dovf_q, dovf_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, ovf_q, ovf_d, dbzo_q, dbzo_d, done_q, done_d;

    // Single-cycle datapath
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf;

    always_comb begin
        sum     = A + B;
        diff    = A - B;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALU_operation)
            4'b0000: alu_res = A & B;
            4'b0001: alu_res = A | B;
            4'b0010: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0110: begin
                alu_res = diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1100: alu_res = ~(A | B);
            4'b0011: alu_res = A ^ B;
            4'b0101: alu_res = B >> A[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // One iteration of multiply (acc:lo shift right) or divide (acc:lo shift left)
    logic [WIDTH:0]   msum, rs, acc_n;
    logic [WIDTH-1:0] lo_n;
    logic             ge;

    always_comb begin
        msum = acc_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rs   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        ge   = rs >= {1'b0, opnd_q};
        if (is_div_q) begin
            acc_n = ge ? (rs - {1'b0, opnd_q}) : rs;
            lo_n  = {lo_q[WIDTH-2:0], ge};
        end else begin
            acc_n = {1'b0, msum[WIDTH:1]};
            lo_n  = {msum[0], lo_q[WIDTH-1:1]};
        end
    end

    logic             sgn;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dbz_d    = dbz_q;
        dovf_d   = dovf_q;
        res_d    = res_q;
        hi_d     = hi_q;
        ovf_d    = ovf_q;
        dbzo_d   = dbzo_q;
        done_d   = 1'b0;
        sgn      = ALU_operation[0];
        mag_a    = (sgn && A[WIDTH-1]) ? (~A + 1'b1) : A;
        mag_b    = (sgn && B[WIDTH-1]) ? (~B + 1'b1) : B;
        prod     = {acc_n[WIDTH-1:0], lo_n};
        if (neg_lo_q) prod = ~prod + 1'b1;
        quo      = neg_lo_q ? (~lo_n + 1'b1) : lo_n;
        rem      = neg_hi_q ? (~acc_n[WIDTH-1:0] + 1'b1) : acc_n[WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ALU_operation[3:2] == 2'b10) begin
                        state_d  = CALC;
                        cnt_d    = '0;
                        acc_d    = '0;
                        lo_d     = mag_a;
                        opnd_d   = mag_b;
                        a_d      = A;
                        is_div_d = ALU_operation[1];
                        neg_lo_d = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_hi_d = sgn && A[WIDTH-1];
                        dbz_d    = ALU_operation[1] && (B == '0);
                        dovf_d   = (ALU_operation == 4'b1011) && (A == MOST_NEG) && (B == '1);
                    end else begin
                        res_d  = alu_res;
                        hi_d   = '0;
                        ovf_d  = alu_ovf;
                        dbzo_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = acc_n;
                lo_d  = lo_n;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ovf_d   = 1'b0;
                    dbzo_d  = 1'b0;
                    if (!is_div_q) begin
                        res_d = prod[WIDTH-1:0];
                        hi_d  = prod[2*WIDTH-1:WIDTH];
                    end else if (dbz_q) begin
                        res_d  = '1;
                        hi_d   = a_q;
                        dbzo_d = 1'b1;
                    end else if (dovf_q) begin
                        res_d = a_q;
                        hi_d  = '0;
                        ovf_d = 1'b1;
                    end else begin
                        res_d = quo;
                        hi_d  = rem;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
            dovf_q   <= 1'b0;
            res_q    <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbzo_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dbz_q    <= dbz_d;
            dovf_q   <= dovf_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            // zero tracks the written result, so it only moves on completion
            if (done_d) zero_q <= (res_d == '0);
            ovf_q    <= ovf_d;
            dbzo_q   <= dbzo_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = done_q;
    assign res         = res_q;
    assign hi          = hi_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_seq_alu_md.sv
// Directed self-checking bench for seq_alu_md at WIDTH=32.
module tb_seq_alu_md;

    logic        clk, rst, start;
    logic [3:0]  opc;
    logic [31:0] ta, tb;
    logic        busy, done, zero, overflow, div_by_zero;
    logic [31:0] res, hi;
    int          n_chk = 0;
    int          n_fail = 0;

    seq_alu_md #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .ALU_operation(opc),
        .A(ta), .B(tb), .busy(busy), .done(done), .res(res), .hi(hi),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {done,busy,res,hi,zero,overflow,div_by_zero}
    logic [68:0] got;
    always_comb got = {done, busy, res, hi, zero, overflow, div_by_zero};

    task automatic run_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int bc);
        @(negedge clk);
        start = 1'b1; opc = op; ta = a; tb = b;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        while (busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opc = '0; ta = '0; tb = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (got !== 69'd0) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", got, 69'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0]  ops [14] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b0111,
                                  4'b0111, 4'b1100, 4'b0011, 4'b0101, 4'b0101, 4'b0100, 4'b1111};
        logic [31:0] as [14] = '{32'hF0F01234, 32'hF0F00000, 32'd1, 32'd1, 32'h7FFFFFFF, 32'h80000000,
                                 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFF00FF00, 32'd4, 32'h24, 32'd5, 32'h7FFFFFFF};
        logic [31:0] bs [14] = '{32'h0FF0FF00, 32'h0000000F, 32'd1, 32'd1, 32'd1, 32'd1,
                                 32'd1, 32'hFFFFFFFF, 32'd0, 32'h0F0F0F0F, 32'h80000000, 32'h80000000, 32'd3, 32'd1};
        logic [31:0] rs [14] = '{32'h00F01200, 32'hF0F0000F, 32'd2, 32'd0, 32'h80000000, 32'h7FFFFFFF,
                                 32'd1, 32'd0, 32'hFFFFFFFF, 32'hF00FF00F, 32'h08000000, 32'h08000000, 32'd0, 32'd0};
        logic        os [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [68:0] exp;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start = 1'b1; opc = ops[i]; ta = as[i]; tb = bs[i];
            @(negedge clk);
            start = 1'b0;
            exp = {1'b1, 1'b0, rs[i], 32'd0, (rs[i] == 32'd0), os[i], 1'b0};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single[%0d] op=%b: got %h want %h", i, ops[i], got, exp);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  ops [8] = '{4'b1001, 4'b1000, 4'b1011, 4'b1010, 4'b1010, 4'b1011, 4'b1011, 4'b1001};
        logic [31:0] as [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'd5,
                                32'h80000000, 32'd7, 32'd0};
        logic [31:0] bs [8] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd7, 32'd0,
                                32'hFFFFFFFF, 32'hFFFFFFFE, 32'd5};
        logic [31:0] rs [8] = '{32'hFFFFFFEB, 32'd1, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF,
                                32'h80000000, 32'hFFFFFFFD, 32'd0};
        logic [31:0] hs [8] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd2, 32'd5,
                                32'd0, 32'd1, 32'd0};
        logic        os [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ds [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [68:0] exp;
        int bc;
        for (int i = 0; i < 8; i++) begin
            run_multi(ops[i], as[i], bs[i], bc);
            n_chk++;
            if (bc !== 32) begin
                n_fail++;
                $display("FAIL muldiv[%0d] busy cycles: got %0d want 32", i, bc);
            end
            exp = {1'b1, 1'b0, rs[i], hs[i], (rs[i] == 32'd0), os[i], ds[i]};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL muldiv[%0d] op=%b: got %h want %h", i, ops[i], got, exp);
            end
        end
        // outputs hold and done drops one cycle later
        @(negedge clk);
        n_chk++;
        if (got !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold: got %h want %h", got, {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_abort();
        int dn;
        @(negedge clk);
        start = 1'b1; opc = 4'b1001; ta = 32'hFFFFFFFD; tb = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; opc = 4'b0010; ta = 32'd2; tb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL ignored start: busy,done got %b want 10", {busy, done});
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (got !== 69'd0) begin
            n_fail++;
            $display("FAIL abort reset: got %h want %h", got, 69'd0);
        end
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        n_chk++;
        if (dn !== 0) begin
            n_fail++;
            $display("FAIL abort no done: got %0d done pulses want 0", dn);
        end
        start = 1'b1; opc = 4'b0010; ta = 32'd2; tb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (got !== {1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add after abort: got %h want %h", got, {1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        @(negedge clk);
        start = 1'b1; opc = 4'b0010; ta = 32'd1; tb = 32'd2;
        @(negedge clk);
        n_chk++;
        if ({done, res} !== {1'b1, 32'd3}) begin
            n_fail++;
            $display("FAIL b2b add: got done=%b res=%h want 1 00000003", done, res);
        end
        opc = 4'b0110; ta = 32'd5; tb = 32'd3;
        @(negedge clk);
        n_chk++;
        if ({done, res} !== {1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL b2b sub: got done=%b res=%h want 1 00000002", done, res);
        end
        opc = 4'b1000; ta = 32'd6; tb = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if ({busy, done, res} !== {1'b1, 1'b0, 32'd2}) begin
            n_fail++;
            $display("FAIL start on done: got busy=%b done=%b res=%h want 1 0 00000002", busy, done, res);
        end
        bc = 0;
        while (busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
        n_chk++;
        if ({bc, done, res, hi} !== {32'd32, 1'b1, 32'd42, 32'd0}) begin
            n_fail++;
            $display("FAIL b2b mulu: got cycles=%0d done=%b res=%h hi=%h want 32 1 0000002a 00000000",
                     bc, done, res, hi);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_muldiv();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
